// File: rtl/subc_scheduler.sv
// subc_scheduler: exposure/subframe sequencer for the coded-exposure imager.
//
// Counts pattern-loader FIFO writes to detect each completed mask, then steps one frame
// through: global-reset mask load/drain, pixel reset, Num_Pat x (subframe mask load/drain,
// exposure), blank mask load and readout. Optionally restarts frames back to back.
//
// Optional feature: define SUBC_TIMEOUT_EN to build the load/drain watchdog. Without it
// err is tied low and load/drain states wait indefinitely.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, starts a frame from idle
//   stop                level, suppresses continuous restart
//   continuous          level, restart a new frame after readout
//   Num_Pat/T_Exp/T_Rst frame configuration, latched at frame start (0 counts as 1)
//   FIFO_wr_mon         loader FIFO write monitor, one mask word per high cycle
//   FIFO_empty          mask FIFO drained into the imager
//   readout_done        pulse from the readout block
//   CntSubc             subframe masks fully loaded in the current frame
//   pix_rst/exp_en      global pixel reset / exposure window
//   readout_req         held in readout until readout_done
//   busy                not idle
//   frame_done          one-cycle pulse at frame end
//   err                 one-cycle pulse on watchdog abort
module subc_scheduler #(
  parameter int unsigned C_NUM_ROWS     = 176,
  parameter int unsigned C_MASK_DES_L   = 16,
  parameter int unsigned WORDS_PER_MASK = C_NUM_ROWS * C_MASK_DES_L,
  parameter int unsigned TIMEOUT_CYC    = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic [31:0] Num_Pat,
  input  logic [31:0] T_Exp,
  input  logic [31:0] T_Rst,
  input  logic        FIFO_wr_mon,
  input  logic        FIFO_empty,
  input  logic        readout_done,
  output logic [31:0] CntSubc,
  output logic        pix_rst,
  output logic        exp_en,
  output logic        readout_req,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  // The word counter is 12 bits wide; reject configurations it cannot count.
  if (WORDS_PER_MASK == 0 || WORDS_PER_MASK > 4096) begin : g_bad_wpm
    $error("WORDS_PER_MASK must be in 1..4096");
  end
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be non-zero");
  end

  localparam logic [11:0] LastWord = 12'(WORDS_PER_MASK - 1);

  typedef enum logic [3:0] {
    StIdle, StLoadRst, StDrainRst, StReset, StLoadSub,
    StDrainSub, StExpose, StLoadBlank, StReadout
  } state_e;

  state_e      r_state, w_state_base, w_state_next;
  logic [11:0] r_wcnt;
  logic [31:0] r_cnt_subc, r_phase;
  logic [31:0] r_num_pat, r_t_exp, r_t_rst;
  logic        r_frame_done;
  logic        w_in_load, w_mask_done, w_frame_start, w_abort;

  always_comb begin
    w_in_load   = (r_state == StLoadRst) || (r_state == StLoadSub) || (r_state == StLoadBlank);
    w_mask_done = w_in_load && FIFO_wr_mon && (r_wcnt == LastWord);
  end

  always_comb begin
    w_state_base  = r_state;
    w_frame_start = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_base  = StLoadRst;
          w_frame_start = 1'b1;
        end
      end
      StLoadRst:   if (w_mask_done) w_state_base = StDrainRst;
      StDrainRst:  if (FIFO_empty) w_state_base = StReset;
      StReset:     if (r_phase == 32'd0) w_state_base = StLoadSub;
      StLoadSub:   if (w_mask_done) w_state_base = StDrainSub;
      StDrainSub:  if (FIFO_empty) w_state_base = StExpose;
      StExpose: begin
        if (r_phase == 32'd0) begin
          w_state_base = (r_cnt_subc >= r_num_pat) ? StLoadBlank : StLoadSub;
        end
      end
      StLoadBlank: if (w_mask_done) w_state_base = StReadout;
      StReadout: begin
        if (readout_done) begin
          if (continuous && !stop) begin
            w_state_base  = StLoadRst;
            w_frame_start = 1'b1;
          end else begin
            w_state_base = StIdle;
          end
        end
      end
      default: w_state_base = StIdle;
    endcase
  end

`ifdef SUBC_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_err;
  logic        w_wait_state;

  // Any write or state change counts as progress and restarts the watchdog.
  always_comb begin
    w_wait_state = w_in_load || (r_state == StDrainRst) || (r_state == StDrainSub);
    w_abort      = w_wait_state && !FIFO_wr_mon && (w_state_base == r_state) &&
                   (r_wdog == 32'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (!w_wait_state || FIFO_wr_mon || (w_state_next != r_state)) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + 32'd1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  assign w_state_next = w_abort ? StIdle : w_state_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_wcnt       <= '0;
      r_cnt_subc   <= '0;
      r_phase      <= '0;
      r_num_pat    <= '0;
      r_t_exp      <= '0;
      r_t_rst      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= (r_state == StReadout) && readout_done;

      if (w_frame_start) begin
        r_num_pat <= (Num_Pat == 32'd0) ? 32'd1 : Num_Pat;
        r_t_exp   <= (T_Exp == 32'd0) ? 32'd1 : T_Exp;
        r_t_rst   <= (T_Rst == 32'd0) ? 32'd1 : T_Rst;
      end

      if (w_abort || (r_state == StIdle) || w_mask_done) begin
        r_wcnt <= '0;
      end else if (w_in_load && FIFO_wr_mon) begin
        r_wcnt <= r_wcnt + 12'd1;
      end

      // Cleared while idle and during the reset-mask load of every new frame.
      if (w_abort || (r_state == StIdle) || (r_state == StLoadRst)) begin
        r_cnt_subc <= '0;
      end else if ((r_state == StLoadSub) && w_mask_done) begin
        r_cnt_subc <= r_cnt_subc + 32'd1;
      end

      // Phase counter runs from (length - 1) down to 0 inside RESET / EXPOSE.
      if (w_abort) begin
        r_phase <= '0;
      end else if ((r_state == StDrainRst) && (w_state_next == StReset)) begin
        r_phase <= r_t_rst - 32'd1;
      end else if ((r_state == StDrainSub) && (w_state_next == StExpose)) begin
        r_phase <= r_t_exp - 32'd1;
      end else if (r_phase != 32'd0) begin
        r_phase <= r_phase - 32'd1;
      end
    end
  end

  assign CntSubc     = r_cnt_subc;
  assign pix_rst     = (r_state == StReset);
  assign exp_en      = (r_state == StExpose);
  assign readout_req = (r_state == StReadout);
  assign busy        = (r_state != StIdle);
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_subc_scheduler.sv
`timescale 1ns/1ps
// tb_subc_scheduler: directed frame sequences with randomized loader gaps, drain delays,
// readout latency, ignored stray inputs and random frame configurations. Expected phase
// lengths and subframe counts come from the frame rules (zero treated as one).
module tb_subc_scheduler;

  localparam int WPM = 176 * 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [31:0] Num_Pat = '0;
  logic [31:0] T_Exp = '0;
  logic [31:0] T_Rst = '0;
  logic        FIFO_wr_mon = 1'b0;
  logic        FIFO_empty = 1'b1;
  logic        readout_done = 1'b0;
  logic [31:0] CntSubc;
  logic        pix_rst, exp_en, readout_req, busy, frame_done, err;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  subc_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .continuous   (continuous),
    .Num_Pat      (Num_Pat),
    .T_Exp        (T_Exp),
    .T_Rst        (T_Rst),
    .FIFO_wr_mon  (FIFO_wr_mon),
    .FIFO_empty   (FIFO_empty),
    .readout_done (readout_done),
    .CntSubc      (CntSubc),
    .pix_rst      (pix_rst),
    .exp_en       (exp_en),
    .readout_req  (readout_req),
    .busy         (busy),
    .frame_done   (frame_done),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference rule: a configured value of zero behaves as one.
  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_rst"}, pix_rst, 0);
    check({tag, "_exp_en"}, exp_en, 0);
    check({tag, "_readout_req"}, readout_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cntsubc"}, CntSubc, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Writes one full mask with occasional idle gaps; sub_k > 0 marks subframe mask k.
  task automatic load_mask(input string tag, input int sub_k);
    FIFO_empty = 1'b0;
    for (int w = 0; w < WPM; w++) begin
      if ($urandom_range(15) == 0) begin
        FIFO_wr_mon = 1'b0;
        @(negedge clk);
      end
      if (sub_k > 0 && w == WPM - 1) check({tag, "_cnt_before_last"}, CntSubc, sub_k - 1);
      FIFO_wr_mon = 1'b1;
      @(negedge clk);
    end
    FIFO_wr_mon = 1'b0;
    if (sub_k > 0) check({tag, "_cnt_after_last"}, CntSubc, sub_k);
  endtask

  // Random drain delay with stray writes, which must be ignored, then FIFO_empty.
  task automatic drain();
    int d;
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      FIFO_wr_mon = 1'($urandom_range(1));
      @(negedge clk);
    end
    FIFO_wr_mon = 1'b0;
    FIFO_empty  = 1'b1;
    @(negedge clk);
  endtask

  task automatic rst_phase(input int len);
    int n;
    load_mask("rst", 0);
    drain();
    check("pix_rst_rise", pix_rst, 1);
    n = 0;
    while (pix_rst === 1'b1 && n < len + 20) begin
      n++;
      FIFO_wr_mon = 1'($urandom_range(1));
      @(negedge clk);
    end
    FIFO_wr_mon = 1'b0;
    check("pix_rst_len", n, len);
  endtask

  task automatic sub_phase(input int k, input int len, input bit raise_stop);
    int n;
    load_mask("sub", k);
    drain();
    check("exp_rise", exp_en, 1);
    check("exp_cntsubc", CntSubc, k);
    n = 0;
    while (exp_en === 1'b1 && n < len + 20) begin
      n++;
      if (raise_stop) stop = 1'b1;
      FIFO_wr_mon = 1'($urandom_range(1));
      start       = 1'($urandom_range(1));
      @(negedge clk);
    end
    FIFO_wr_mon = 1'b0;
    start       = 1'b0;
    check("exp_len", n, len);
  endtask

  task automatic blank_readout(input bit exp_busy, input int np);
    int h;
    int bad;
    load_mask("blank", 0);
    check("readout_req_rise", readout_req, 1);
    check("cnt_in_readout", CntSubc, np);
    h   = $urandom_range(1, 5);
    bad = 0;
    for (int i = 0; i < h; i++) begin
      if (readout_req !== 1'b1 || frame_done !== 1'b0) bad++;
      FIFO_wr_mon = 1'($urandom_range(1));
      @(negedge clk);
    end
    FIFO_wr_mon  = 1'b0;
    check("readout_req_held", bad, 0);
    readout_done = 1'b1;
    @(negedge clk);
    readout_done = 1'b0;
    check("frame_done_pulse", frame_done, 1);
    check("readout_req_fall", readout_req, 0);
    check("busy_after_frame", busy, exp_busy);
    @(negedge clk);
    check("frame_done_single", frame_done, 0);
    if (!exp_busy) begin
      check("idle_cnt_clear", CntSubc, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  // np/te/tr are the values latched at this frame's start.
  task automatic run_frame(input int np, input int te, input int tr, input bit exp_busy);
    rst_phase(eff(tr));
    for (int k = 1; k <= eff(np); k++) sub_phase(k, eff(te), 1'b0);
    blank_readout(exp_busy, eff(np));
  endtask

  initial begin
    int np, te, tr;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", busy, 0);

    // Basic frame; inputs changed after start must not affect this frame
    Num_Pat = 32'd3; T_Exp = 32'd10; T_Rst = 32'd5;
    do_start();
    Num_Pat = 32'd1; T_Exp = 32'd3; T_Rst = 32'd9;
    run_frame(3, 10, 5, 1'b0);

    // Mid-frame reset during the exposure of subframe 2
    Num_Pat = 32'd3;
    te = $urandom_range(4, 12);
    tr = $urandom_range(1, 8);
    T_Exp = 32'(te); T_Rst = 32'(tr);
    do_start();
    rst_phase(eff(tr));
    sub_phase(1, eff(te), 1'b0);
    load_mask("sub", 2);
    drain();
    check("abort_exp_rise", exp_en, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_busy", busy, 0);
    check("post_abort_exp_en", exp_en, 0);

    // Zero configuration after the abort
    Num_Pat = 32'd0; T_Exp = 32'd0; T_Rst = 32'd0;
    do_start();
    run_frame(0, 0, 0, 1'b0);

    // Continuous mode with configuration changes, stop raised in frame 2 exposure
    continuous = 1'b1; stop = 1'b0;
    Num_Pat = 32'd1; T_Exp = 32'd10; T_Rst = 32'd3;
    do_start();
    rst_phase(3);
    T_Exp = 32'd20; T_Rst = 32'd7;
    sub_phase(1, 10, 1'b0);
    blank_readout(1'b1, 1);
    rst_phase(7);
    sub_phase(1, 20, 1'b1);
    blank_readout(1'b0, 1);
    continuous = 1'b0; stop = 1'b0;

    // Random configuration frame
    np = $urandom_range(1, 2);
    te = $urandom_range(0, 12);
    tr = $urandom_range(0, 12);
    Num_Pat = 32'(np); T_Exp = 32'(te); T_Rst = 32'(tr);
    do_start();
    run_frame(np, te, tr, 1'b0);
    check("final_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL global_timeout: simulation still running at %0t, required to have finished",
             $time);
    $fatal(1, "timeout");
  end

endmodule
